avalon_mm_pattern_master: RTL and testbench
===========================================

Name: avalon_mm_pattern_master

Overview:
Parametrised Avalon-MM master engine that replaces the host-driven bridge master for SDRAM controller bring-up. It fills an address range with a generated pattern, then reads the range back with pipelined reads and compares every word on-chip. It reports the error count and first-failure information. It sits between a control/status register block and the SDRAM controller's Avalon-MM slave port.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, data width; multiple of 8, 8..128
MAX_OUTSTANDING, 4, max reads in flight (1..16)
LEN_W, 16, width of word_count
ERR_W, 16, width of error_count (saturating)

Ports:
clk_clk  in  1  single clock
reset_reset  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; latched only in IDLE
abort  in  1  level; stop issuing new commands, drain outstanding reads
mode  in  2  0=write only, 1=read-check only, 2=write then read-check, 3=reserved (treated as 2)
pat_sel  in  1  0=incrementing, 1=LFSR
seed  in  32  pattern seed
base_addr  in  ADDR_W  start byte address, BE_W-aligned (low bits ignored)
word_count  in  LEN_W  number of DATA_W words
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at completion
aborted  out  1  sticky until next start; set if abort ended the run
error_count  out  ERR_W  mismatching words, saturating
first_err_addr  out  ADDR_W  address of the first mismatch
first_err_data  out  DATA_W  read data of the first mismatch
master_address  out  ADDR_W  Avalon byte address
master_read  out  1
master_write  out  1
master_writedata  out  DATA_W
master_byteenable  out  DATA_W/8  always all ones while read or write is asserted; else 0
master_waitrequest  in  1
master_readdata  in  DATA_W
master_readdatavalid  in  1

Behaviour:
- Reset: state IDLE. All outputs 0: busy, done, aborted, error_count, first_err_*, read, write, byteenable, address, writedata. Outstanding counter 0. Reset takes effect on the next edge even mid-run. readdatavalid pulses after reset with outstanding=0 are ignored.
- Inputs are sampled on start in IDLE: mode, pat_sel, seed, base_addr, word_count. A start in any other state is ignored.
- The error_count, first_err_*, and aborted outputs clear on an accepted start.
- Pattern for word index i:
  - INCR: data = (seed + i) zero-extended or truncated to DATA_W.
  - LFSR: 32-bit Galois LFSR, taps 0x80200003, state0 = seed (seed 0 is forced to 1), advanced once per word. data = state replicated across DATA_W, truncated.
  - Two independent generators exist: the issue-side generator, and the check-side generator that advances per readdatavalid. Both are reset to index 0 at the start of each phase.
- Address for word i: base_addr + i*(DATA_W/8), modulo 2^ADDR_W. Wrap-around is permitted.
- States:
  - IDLE
  - WR: assert write with address/data for index i. Hold all signals stable while waitrequest=1. Advance i when waitrequest=0. After the last word, go to RD (mode 2) or FIN (mode 0).
  - RD: assert read. Advance when waitrequest=0. The read is deasserted while outstanding==MAX_OUTSTANDING. After the last read is accepted, go to DRAIN.
  - DRAIN: wait until outstanding==0, then go to FIN.
  - FIN: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- mode 1 goes IDLE→RD. word_count=0 goes IDLE→FIN, with done 2 cycles after start and no bus activity.
- Outstanding counter: +1 on an accepted read, -1 on readdatavalid. Both in the same cycle leave it unchanged. It never exceeds MAX_OUTSTANDING.
- Compare: on readdatavalid, compare readdata against the check-side pattern (all DATA_W bits).
  - On mismatch, error_count increments, saturating at all ones.
  - On the first mismatch of a run, capture first_err_addr (address of that word; responses are in order) and first_err_data.
- Abort (sampled each cycle in WR/RD):
  - No new command starts after abort is seen.
  - A command currently stalled by waitrequest is held until accepted (Avalon rule).
  - Then go to DRAIN, set aborted, and pulse done as normal.
- Latency: first command is asserted the cycle after start is accepted. Throughput is 1 word/cycle when waitrequest=0 and read latency fits within MAX_OUTSTANDING.
- busy=1 from the cycle after an accepted start through the done cycle.

Test Plan:
1. mode 2, INCR, seed=0x100, base=0x0, count=8, waitrequest=0, slave model 3-cycle read latency:
   - writes of 0x100..0x107 to 0x0..0x1C;
   - 8 reads, outstanding ≤4;
   - done pulse, error_count=0.
2. Same run with the slave corrupting word 5 (bit 0 flipped) and word 6 → error_count=2, first_err_addr=0x14, first_err_data=0x104.
3. Random waitrequest (50%) during mode 2, LFSR, seed=0 → signals are stable while stalled, LFSR starts from 1, error_count=0, exactly count writes and count reads.
4. count=0, mode 2 → no read or write asserted, done exactly 2 cycles after start.
5. abort raised mid-RD with 3 reads outstanding and a read stalled by waitrequest → stalled read completes, no further reads issue, done after the 4 responses return, aborted=1.
6. reset_reset asserted mid-WR, then readdatavalid pulses arrive → next cycle all outputs 0; stray pulses do not change error_count; a new start runs normally; start while busy is ignored.

Source files
------------

// File: rtl/avalon_mm_pattern_master_if.sv
// Avalon-MM bus bundle between the pattern master and an SDRAM controller slave port.
interface avalon_mm_pattern_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] master_address;
  logic              master_read;
  logic              master_write;
  logic [DATA_W-1:0] master_writedata;
  logic [BE_W-1:0]   master_byteenable;
  logic              master_waitrequest;
  logic [DATA_W-1:0] master_readdata;
  logic              master_readdatavalid;

  modport master (
    output master_address,
    output master_read,
    output master_write,
    output master_writedata,
    output master_byteenable,
    input  master_waitrequest,
    input  master_readdata,
    input  master_readdatavalid
  );

  modport slave (
    input  master_address,
    input  master_read,
    input  master_write,
    input  master_writedata,
    input  master_byteenable,
    output master_waitrequest,
    output master_readdata,
    output master_readdatavalid
  );
endinterface

// File: rtl/avalon_mm_pattern_master.sv
// Pattern fill / pipelined read-back checker acting as an Avalon-MM master for SDRAM bring-up.
// Writes a generated pattern over an address range, reads it back and counts mismatches.
module avalon_mm_pattern_master #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LEN_W           = 16,
  parameter int ERR_W           = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic              pat_sel,
  input  logic [31:0]       seed,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ERR_W-1:0]  error_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  avalon_mm_pattern_master_if.master avm
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int NREP  = (DATA_W + 31) / 32;
  // Generator state: 33 bits so seed + index never overflows before zero-extension.
  localparam int GEN_W = 33;
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BE_W);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BE_W - 1);
  localparam logic [OUT_W-1:0]  OUT_MAX    = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_DRAIN,
    S_FIN
  } state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [GEN_W-1:0] gen_init(input logic [31:0] s, input logic sel);
    if (sel && (s == 32'd0)) gen_init = GEN_W'(1);
    else                     gen_init = {1'b0, s};
  endfunction

  function automatic logic [GEN_W-1:0] gen_next(input logic [GEN_W-1:0] v, input logic sel);
    if (sel) gen_next = {1'b0, lfsr_step(v[31:0])};
    else     gen_next = v + GEN_W'(1);
  endfunction

  function automatic logic [DATA_W-1:0] gen_pattern(input logic [GEN_W-1:0] v, input logic sel);
    logic [32*NREP-1:0] rep;
    rep = {NREP{v[31:0]}};
    if (sel) gen_pattern = rep[DATA_W-1:0];
    else     gen_pattern = DATA_W'(v);
  endfunction

  state_t            state_q;
  logic              busy_q, done_q, aborted_q, abort_pend_q;
  logic [ERR_W-1:0]  error_count_q;
  logic [ADDR_W-1:0] first_err_addr_q;
  logic [DATA_W-1:0] first_err_data_q;
  logic              read_q, write_q;
  logic [BE_W-1:0]   be_q;
  logic [ADDR_W-1:0] address_q;
  logic [DATA_W-1:0] writedata_q;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [LEN_W-1:0]  rem_q;
  logic [GEN_W-1:0]  iss_q, chk_q, gen0_q;
  logic [ADDR_W-1:0] chk_addr_q, base_q;
  logic [LEN_W-1:0]  count_q;
  logic              pat_sel_q, wr_only_q;

  logic              wr_acc, rd_acc, rdv_ok, mismatch, abort_eff, below_max;
  logic [GEN_W-1:0]  iss_nx, start_gen0;
  logic [DATA_W-1:0] chk_pat;
  logic [ADDR_W-1:0] base_al;

  assign wr_acc     = write_q && !avm.master_waitrequest;
  assign rd_acc     = read_q && !avm.master_waitrequest;
  // Responses with nothing in flight (e.g. stragglers after a reset) are dropped.
  assign rdv_ok     = avm.master_readdatavalid && (out_q != '0);
  assign out_d      = out_q + OUT_W'(rd_acc) - OUT_W'(rdv_ok);
  assign below_max  = out_d < OUT_MAX;
  assign abort_eff  = abort || abort_pend_q;
  assign iss_nx     = gen_next(iss_q, pat_sel_q);
  assign chk_pat    = gen_pattern(chk_q, pat_sel_q);
  assign mismatch   = rdv_ok && (avm.master_readdata != chk_pat);
  assign start_gen0 = gen_init(seed, pat_sel);
  assign base_al    = base_addr & ALIGN_MASK;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q          <= S_IDLE;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      aborted_q        <= 1'b0;
      abort_pend_q     <= 1'b0;
      error_count_q    <= '0;
      first_err_addr_q <= '0;
      first_err_data_q <= '0;
      read_q           <= 1'b0;
      write_q          <= 1'b0;
      be_q             <= '0;
      address_q        <= '0;
      writedata_q      <= '0;
      out_q            <= '0;
      rem_q            <= '0;
      iss_q            <= '0;
      chk_q            <= '0;
      gen0_q           <= '0;
      chk_addr_q       <= '0;
      base_q           <= '0;
      count_q          <= '0;
      pat_sel_q        <= 1'b0;
      wr_only_q        <= 1'b0;
    end else begin
      out_q <= out_d;

      if (rdv_ok) begin
        chk_q      <= gen_next(chk_q, pat_sel_q);
        chk_addr_q <= chk_addr_q + ADDR_STEP;
        if (mismatch) begin
          if (error_count_q != '1) error_count_q <= error_count_q + ERR_W'(1);
          if (error_count_q == '0) begin
            first_err_addr_q <= chk_addr_q;
            first_err_data_q <= avm.master_readdata;
          end
        end
      end

      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (start && !busy_q) begin
            busy_q           <= 1'b1;
            aborted_q        <= 1'b0;
            abort_pend_q     <= 1'b0;
            error_count_q    <= '0;
            first_err_addr_q <= '0;
            first_err_data_q <= '0;
            pat_sel_q        <= pat_sel;
            wr_only_q        <= (mode == 2'd0);
            gen0_q           <= start_gen0;
            base_q           <= base_al;
            count_q          <= word_count;
            iss_q            <= start_gen0;
            rem_q            <= word_count;
            address_q        <= base_al;
            if (word_count == '0) begin
              state_q <= S_FIN;
            end else if (mode == 2'd1) begin
              state_q    <= S_RD;
              read_q     <= 1'b1;
              be_q       <= '1;
              chk_q      <= start_gen0;
              chk_addr_q <= base_al;
            end else begin
              state_q     <= S_WR;
              write_q     <= 1'b1;
              be_q        <= '1;
              writedata_q <= gen_pattern(start_gen0, pat_sel);
            end
          end
        end

        S_WR: begin
          if (abort) abort_pend_q <= 1'b1;
          if (wr_acc) begin
            if (rem_q == LEN_W'(1)) begin
              write_q <= 1'b0;
              if (wr_only_q) begin
                be_q    <= '0;
                state_q <= S_FIN;
              end else if (abort_eff) begin
                be_q      <= '0;
                aborted_q <= 1'b1;
                state_q   <= S_DRAIN;
              end else begin
                // Read-back starts immediately from the top of the range.
                state_q    <= S_RD;
                read_q     <= 1'b1;
                address_q  <= base_q;
                rem_q      <= count_q;
                chk_q      <= gen0_q;
                chk_addr_q <= base_q;
              end
            end else if (abort_eff) begin
              write_q   <= 1'b0;
              be_q      <= '0;
              aborted_q <= 1'b1;
              state_q   <= S_DRAIN;
            end else begin
              iss_q       <= iss_nx;
              rem_q       <= rem_q - LEN_W'(1);
              address_q   <= address_q + ADDR_STEP;
              writedata_q <= gen_pattern(iss_nx, pat_sel_q);
            end
          end
        end

        S_RD: begin
          if (abort) abort_pend_q <= 1'b1;
          // A stalled read must stay asserted unchanged until the slave takes it.
          if (!(read_q && avm.master_waitrequest)) begin
            if (rd_acc && (rem_q == LEN_W'(1))) begin
              read_q  <= 1'b0;
              be_q    <= '0;
              state_q <= S_DRAIN;
            end else if (abort_eff) begin
              read_q    <= 1'b0;
              be_q      <= '0;
              aborted_q <= 1'b1;
              state_q   <= S_DRAIN;
            end else begin
              read_q <= below_max;
              be_q   <= {BE_W{below_max}};
            end
            if (rd_acc) begin
              rem_q     <= rem_q - LEN_W'(1);
              address_q <= address_q + ADDR_STEP;
            end
          end
        end

        S_DRAIN: begin
          if (out_q == '0) state_q <= S_FIN;
        end

        S_FIN: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy                  = busy_q;
  assign done                  = done_q;
  assign aborted               = aborted_q;
  assign error_count           = error_count_q;
  assign first_err_addr        = first_err_addr_q;
  assign first_err_data        = first_err_data_q;
  assign avm.master_address    = address_q;
  assign avm.master_read       = read_q;
  assign avm.master_write      = write_q;
  assign avm.master_writedata  = writedata_q;
  assign avm.master_byteenable = be_q;

endmodule

// File: tb/tb_avalon_mm_pattern_master.sv
// Directed bench: pattern master against a queued-response Avalon slave memory model.
module tb_avalon_mm_pattern_master;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;
  localparam int ERR_W  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_reset, start, abort, pat_sel;
  logic [1:0]        mode;
  logic [31:0]       seed;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  word_count;
  logic              busy, done, aborted;
  logic [ERR_W-1:0]  error_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic [DATA_W-1:0] first_err_data;

  avalon_mm_pattern_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  avalon_mm_pattern_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(4), .LEN_W(LEN_W), .ERR_W(ERR_W)
  ) dut (
    .clk_clk(clk), .reset_reset(reset_reset), .start(start), .abort(abort),
    .mode(mode), .pat_sel(pat_sel), .seed(seed), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done), .aborted(aborted),
    .error_count(error_count), .first_err_addr(first_err_addr),
    .first_err_data(first_err_data), .avm(bus)
  );

  // Slave controls
  logic        rand_on = 1'b0, wr_rand = 1'b0, wr_man = 1'b0;
  logic        hold_resp = 1'b0, corrupt_en = 1'b0, rdv_force = 1'b0;
  logic        rdv_r = 1'b0;
  logic [31:0] rdata_r = '0;

  assign bus.master_waitrequest   = rand_on ? wr_rand : wr_man;
  assign bus.master_readdatavalid = rdv_r | rdv_force;
  assign bus.master_readdata      = rdv_force ? 32'hDEAD_BEEF : rdata_r;

  initial forever begin
    @(negedge clk);
    wr_rand = 1'($urandom_range(0, 1));
  end

  typedef struct {
    logic [31:0] d;
    int          rdy;
  } resp_t;
  resp_t rq[$];

  logic [31:0] mem [256];
  int cyc = 0, wr_cnt = 0, rd_cnt = 0, rdv_cnt = 0, done_cnt = 0;
  int tb_out = 0, max_out = 0, stall_viol = 0;
  logic              p_stall = 1'b0, p_rd = 1'b0, p_wr = 1'b0;
  logic [ADDR_W-1:0] p_addr = '0;
  logic [DATA_W-1:0] p_wd = '0;
  logic [3:0]        p_be = '0;

  // Memory slave with 3-cycle read latency; responses can be held back on demand.
  always @(posedge clk) begin : slave
    int          idx;
    logic [31:0] d;
    cyc++;
    if (p_stall && (bus.master_read != p_rd || bus.master_write != p_wr ||
                    bus.master_address != p_addr || bus.master_byteenable != p_be ||
                    (p_wr && bus.master_writedata != p_wd)))
      stall_viol++;
    p_stall = (bus.master_read || bus.master_write) && bus.master_waitrequest;
    p_rd = bus.master_read; p_wr = bus.master_write; p_addr = bus.master_address;
    p_wd = bus.master_writedata; p_be = bus.master_byteenable;
    if (done) done_cnt++;
    if (rdv_r) begin
      void'(rq.pop_front());
      rdv_cnt++;
      tb_out--;
    end
    idx = int'(bus.master_address[9:2]);
    if (bus.master_write && !bus.master_waitrequest) begin
      mem[idx] = bus.master_writedata;
      wr_cnt++;
    end
    if (bus.master_read && !bus.master_waitrequest) begin
      d = mem[idx];
      if (corrupt_en && (idx == 5 || idx == 6)) d = d ^ 32'h1;
      rq.push_back('{d: d, rdy: cyc + 2});
      rd_cnt++;
      tb_out++;
      if (tb_out > max_out) max_out = tb_out;
    end
    if (!hold_resp && rq.size() > 0 && rq[0].rdy <= cyc) begin
      rdv_r   <= 1'b1;
      rdata_r <= rq[0].d;
    end else begin
      rdv_r   <= 1'b0;
      rdata_r <= '0;
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [1:0] m, input logic p, input logic [31:0] s,
                           input logic [31:0] b, input logic [15:0] c);
    @(negedge clk);
    mode = m; pat_sel = p; seed = s; base_addr = b; word_count = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int rdv_at_done);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    rdv_at_done = rdv_cnt;
    chk(tag, done, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end expected summary");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, r0, v0, d0, vd, n;
    reset_reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; pat_sel = 1'b0;
    seed = '0; base_addr = '0; word_count = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", error_count, 16'd0);
    chk("rst_rw_be", {bus.master_read, bus.master_write, bus.master_byteenable}, 6'd0);
    chk("rst_addr", bus.master_address, 32'd0);
    reset_reset = 1'b0;

    // 1: mode 2, INCR, seed 0x100, 8 words, no stalls
    w0 = wr_cnt; r0 = rd_cnt;
    start_run(2'd2, 1'b0, 32'h100, 32'h0, 16'd8);
    chk("t1_busy", busy, 1'b1);
    chk("t1_first_write", {bus.master_write, bus.master_address}, {1'b1, 32'h0});
    chk("t1_first_wdata", bus.master_writedata, 32'h100);
    wait_done("t1_done", vd);
    for (int i = 0; i < 8; i++) chk($sformatf("t1_mem%0d", i), mem[i], 32'h100 + 32'(i));
    chk("t1_writes", wr_cnt - w0, 8);
    chk("t1_reads", rd_cnt - r0, 8);
    chk("t1_max_out_le4", (max_out <= 4), 1'b1);
    chk("t1_err", error_count, 16'd0);
    chk("t1_busy_after", busy, 1'b0);

    // 2: same run, slave corrupts words 5 and 6 on read
    corrupt_en = 1'b1;
    start_run(2'd2, 1'b0, 32'h100, 32'h0, 16'd8);
    wait_done("t2_done", vd);
    corrupt_en = 1'b0;
    chk("t2_err", error_count, 16'd2);
    chk("t2_first_addr", first_err_addr, 32'h14);
    chk("t2_first_data", first_err_data, 32'h104);
    chk("t2_aborted", aborted, 1'b0);

    // 3: random waitrequest, LFSR with seed 0
    w0 = wr_cnt; r0 = rd_cnt;
    rand_on = 1'b1;
    start_run(2'd2, 1'b1, 32'h0, 32'h100, 16'd8);
    wait_done("t3_done", vd);
    rand_on = 1'b0;
    chk("t3_lfsr0", mem[64], 32'h1);
    chk("t3_lfsr1", mem[65], 32'h8020_0003);
    chk("t3_lfsr2", mem[66], 32'hC030_0002);
    chk("t3_err", error_count, 16'd0);
    chk("t3_writes", wr_cnt - w0, 8);
    chk("t3_reads", rd_cnt - r0, 8);
    chk("t3_stall_stable", stall_viol, 0);
    chk("t3_max_out_le4", (max_out <= 4), 1'b1);

    // 4: zero-length run
    w0 = wr_cnt; r0 = rd_cnt;
    start_run(2'd2, 1'b0, 32'h0, 32'h0, 16'd0);
    chk("t4_c1_busy_done", {busy, done}, 2'b10);
    @(negedge clk);
    chk("t4_c2_done", done, 1'b1);
    @(negedge clk);
    chk("t4_c3_busy_done", {busy, done}, 2'b00);
    chk("t4_no_bus", (wr_cnt - w0) + (rd_cnt - r0), 0);

    // 5: abort with 3 reads in flight and a 4th stalled
    hold_resp = 1'b1;
    r0 = rd_cnt; v0 = rdv_cnt;
    start_run(2'd1, 1'b0, 32'h100, 32'h0, 16'd16);
    n = 0;
    while ((rd_cnt - r0) < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t5_three_issued", rd_cnt - r0, 3);
    chk("t5_read_pending", bus.master_read, 1'b1);
    wr_man = 1'b1; abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    wr_man = 1'b0;
    @(negedge clk);
    chk("t5_stalled_completed", rd_cnt - r0, 4);
    chk("t5_still_busy", busy, 1'b1);
    hold_resp = 1'b0;
    wait_done("t5_done", vd);
    chk("t5_resp_before_done", vd - v0, 4);
    chk("t5_no_more_reads", rd_cnt - r0, 4);
    chk("t5_aborted", aborted, 1'b1);
    chk("t5_err", error_count, 16'd0);
    chk("t5_stall_stable", stall_viol, 0);

    // 6: reset mid-write, stray responses, fresh run, start while busy
    start_run(2'd2, 1'b0, 32'h300, 32'h80, 16'd8);
    @(negedge clk);
    chk("t6_in_write", bus.master_write, 1'b1);
    reset_reset = 1'b1;
    @(negedge clk);
    reset_reset = 1'b0;
    chk("t6_busy_done_ab", {busy, done, aborted}, 3'b000);
    chk("t6_rw_be", {bus.master_read, bus.master_write, bus.master_byteenable}, 6'd0);
    chk("t6_addr", bus.master_address, 32'd0);
    chk("t6_wdata", bus.master_writedata, 32'd0);
    chk("t6_err_info", {error_count, first_err_addr, first_err_data}, 80'd0);
    rdv_force = 1'b1;
    repeat (2) @(negedge clk);
    rdv_force = 1'b0;
    @(negedge clk);
    chk("t6_stray_err", error_count, 16'd0);
    w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
    start_run(2'd2, 1'b0, 32'h200, 32'h40, 16'd4);
    mode = 2'd0; word_count = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t6_done", vd);
    repeat (3) @(negedge clk);
    chk("t6_writes", wr_cnt - w0, 4);
    chk("t6_reads", rd_cnt - r0, 4);
    chk("t6_one_done", done_cnt - d0, 1);
    chk("t6_err", error_count, 16'd0);
    chk("t6_aborted", aborted, 1'b0);
    chk("t6_mem16", mem[16], 32'h200);
    chk("t6_mem19", mem[19], 32'h203);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
